mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, maximum consecutive data-port grants while instruction request pends.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous reset, active-high.
REQ-006 SHALL have port if_req  in  1  instruction-fetch request, held until if_ack.
REQ-007 SHALL have port if_addr  in  ADDR_W  fetch address.
REQ-008 SHALL have port if_rdata  out  DATA_W  fetched word, valid while if_ack=1.
REQ-009 SHALL have port if_ack  out  1  one-cycle completion pulse, fetch port.
REQ-010 SHALL have port dm_req  in  1  data-memory request, held until dm_ack.
REQ-011 SHALL have port dm_we  in  1  1=store, 0=load.
REQ-012 SHALL have ports dm_addr  in  ADDR_W and dm_wdata  in  DATA_W  data access address and store data.
REQ-013 SHALL have port dm_rdata  out  DATA_W  load data, valid while dm_ack=1.
REQ-014 SHALL have port dm_ack  out  1  one-cycle completion pulse, data port.
REQ-015 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W  shared single-port memory request.
REQ-016 SHALL have ports mem_rdata in DATA_W, mem_ready in 1  memory response; access completes in the cycle mem_ready=1 while mem_req=1.
REQ-017 SHALL have ports stall_if out 1, stall_mem out 1  pipeline freeze requests.

Function
REQ-018 SHALL implement FSM states IDLE, IF_BUSY, DM_BUSY, RESP; owner register records the granted port (IF/DM).
REQ-019 IDLE: dm_req=1 and (if_req=0 or wait_cnt<MAX_WAIT) -> DM_BUSY; else if_req=1 -> IF_BUSY; else stay IDLE.
REQ-020 At the grant edge SHALL latch address, we (0 for IF), and wdata of the granted port into mem_addr/mem_we/mem_wdata; these hold constant through the BUSY state.
REQ-021 mem_req SHALL be 1 exactly in IF_BUSY and DM_BUSY.
REQ-022 BUSY with mem_ready=1 -> RESP, latching mem_rdata; mem_ready=0 -> remain BUSY (no timeout).
REQ-023 RESP SHALL last exactly one cycle, assert if_ack or dm_ack (per owner) with latched data on the matching rdata port, then -> IDLE.
REQ-024 Minimum latency: request seen in IDLE at cycle t, mem_ready=1 at t+1 -> ack at t+2; back-to-back throughput one access per 3 cycles.
REQ-025 A request still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-026 wait_cnt SHALL increment (saturating at MAX_WAIT) on each DM grant made while if_req=1, and clear to 0 on each IF grant.
REQ-027 dm_rdata on stores SHALL be whatever mem_rdata was latched; ack timing identical to loads.
REQ-028 stall_if SHALL equal if_req AND NOT if_ack; stall_mem SHALL equal dm_req AND NOT dm_ack (combinational from registered state).
REQ-029 Requests arriving in BUSY or RESP SHALL be ignored until IDLE; no request is lost while its req is held.
REQ-030 Request changes from the non-owner during an access SHALL NOT affect mem_* outputs.

Reset
REQ-031 rst=1 at a rising edge SHALL force IDLE, wait_cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0 from the next cycle.
REQ-032 Reset during BUSY/RESP SHALL abort the access without any ack pulse; mem_req drops the cycle after rst is sampled.

Verification
REQ-033 Single fetch: if_req=1, if_addr=0x40, mem_ready=1 at first mem_req cycle, mem_rdata=0x2010000A -> mem_addr=0x40, mem_we=0, if_ack at t+2 with if_rdata=0x2010000A, stall_if 1 until ack.
REQ-034 Collision: if_req and dm_req (we=1, addr=0x100, wdata=0xDEAD) rise same cycle -> DM granted first (mem_we=1, mem_addr=0x100), IF granted next IDLE.
REQ-035 Starvation: if_req and dm_req held high, dm re-requesting each IDLE -> exactly 4 DM grants, then IF grant, wait_cnt back to 0.
REQ-036 Slow memory: mem_ready held 0 for 5 cycles -> mem_req stays 1, mem_addr stable, no ack; ack one cycle after mem_ready=1.
REQ-037 Reset mid-access: rst=1 in DM_BUSY -> next cycle mem_req=0, state IDLE, no dm_ack ever for that access.
REQ-038 Idle: no requests for 10 cycles -> mem_req=0, acks 0, stalls 0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared single-port memory.
// Latency: grant on the edge after a request is seen in IDLE; ack two cycles later at best (one access per 3 cycles).
// Backpressure: mem_ready=0 holds the BUSY state indefinitely; stall_if/stall_mem freeze the requesting pipeline stages.
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam int WC_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;
   typedef enum logic {OWN_IF, OWN_DM} owner_t;

   state_t          state;
   owner_t          owner;
   logic [WC_W-1:0] wait_cnt;
   logic            dm_wins;

   // Data port has priority, except once fetch has been passed over MAX_WAIT times in a row
   assign dm_wins = dm_req && (!if_req || (wait_cnt < WC_MAX));

   // Arbitration FSM; all memory-side and ack outputs are registered here
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= OWN_IF;
         wait_cnt  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         dm_ack    <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         if_ack <= 1'b0;
         dm_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (dm_wins) begin
                  state     <= DM_BUSY;
                  owner     <= OWN_DM;
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  // dm_wins with if_req pending implies wait_cnt < WC_MAX, so this saturates naturally
                  if (if_req) wait_cnt <= wait_cnt + 1'b1;
               end else if (if_req) begin
                  state     <= IF_BUSY;
                  owner     <= OWN_IF;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  wait_cnt  <= '0;
               end
            end
            IF_BUSY, DM_BUSY: begin
               // Address/data stay frozen until memory answers; there is no timeout
               if (mem_ready) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  if (owner == OWN_IF) begin
                     if_ack   <= 1'b1;
                     if_rdata <= mem_rdata;
                  end else begin
                     dm_ack   <= 1'b1;
                     dm_rdata <= mem_rdata;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Freeze a requester until the cycle its ack is visible
   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: queue-driven requesters, a latency-programmable memory model,
// and scoreboards of expected grants and acks in predicted arbitration order.
// Memory answers rd_model(addr) for every access, loads and stores alike.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        is_dm;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } acc_t;

   typedef struct packed {
      logic        is_dm;
      logic [31:0] data;
   } ack_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        stall_if;
   logic        stall_mem;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int mem_lat = 0;
   logic rst_q = 1'b1;

   logic [31:0] if_todo[$];
   acc_t        dm_todo[$];
   acc_t        exp_grant[$];
   ack_t        exp_ack[$];
   int          ack_cycs[$];
   int          ready_cyc = 0;
   int          grant_cyc = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      if (a == 32'h40) return 32'h2010000A;
      return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   // Requesters: hold the head of each queue on the port, retire it when its ack is seen
   always @(posedge clk) begin
      logic [31:0] t_a;
      acc_t        t_d;
      #1;
      if (if_ack && if_todo.size() > 0) t_a = if_todo.pop_front();
      if (if_todo.size() > 0) begin
         if_req  = 1'b1;
         if_addr = if_todo[0];
      end else begin
         if_req = 1'b0;
      end
      if (dm_ack && dm_todo.size() > 0) t_d = dm_todo.pop_front();
      if (dm_todo.size() > 0) begin
         dm_req   = 1'b1;
         dm_we    = dm_todo[0].we;
         dm_addr  = dm_todo[0].addr;
         dm_wdata = dm_todo[0].wdata;
      end else begin
         dm_req = 1'b0;
      end
   end

   // Memory model: checks each grant against the expected order, checks hold-stability, answers after mem_lat cycles
   always @(negedge clk) begin
      static logic        in_access = 1'b0;
      static logic        ready_given = 1'b0;
      static int          busy_cnt = 0;
      static logic [31:0] held_addr = '0;
      static logic [31:0] held_wdata = '0;
      static logic        held_we = 1'b0;
      acc_t g;
      if (mem_req) begin
         if (!in_access) begin
            in_access   = 1'b1;
            ready_given = 1'b0;
            busy_cnt    = 0;
            grant_cyc   = cyc;
            if (exp_grant.size() == 0) begin
               check_val("grant_unexpected", {mem_we, mem_addr}, 0);
            end else begin
               g = exp_grant.pop_front();
               check_val("grant_we", mem_we, g.we);
               check_val("grant_addr", mem_addr, g.addr);
               if (g.is_dm) check_val("grant_wdata", mem_wdata, g.wdata);
            end
            held_addr  = mem_addr;
            held_wdata = mem_wdata;
            held_we    = mem_we;
         end else begin
            check_val("hold_addr", mem_addr, held_addr);
            check_val("hold_wdata", mem_wdata, held_wdata);
            check_val("hold_we", mem_we, held_we);
         end
         if (busy_cnt >= mem_lat) begin
            mem_ready   = 1'b1;
            mem_rdata   = rd_model(mem_addr);
            ready_given = 1'b1;
            ready_cyc   = cyc;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'hBAD0BAD0;
            busy_cnt++;
         end
      end else begin
         if (in_access) check_val("mem_req_early_drop", ready_given | rst_q, 1);
         in_access = 1'b0;
         mem_ready = 1'b0;
      end
   end

   // Ack scoreboard and stall checks every cycle
   always @(negedge clk) begin
      ack_t a;
      if (if_ack && dm_ack) check_val("both_acks", 1, 0);
      if (if_ack || dm_ack) begin
         ack_cycs.push_back(cyc);
         if (exp_ack.size() == 0) begin
            check_val("ack_unexpected", {if_ack, dm_ack}, 0);
         end else begin
            a = exp_ack.pop_front();
            check_val("ack_port", dm_ack, a.is_dm);
            check_val("ack_data", dm_ack ? dm_rdata : if_rdata, a.data);
         end
      end
      check_val("stall_if", stall_if, if_req && !if_ack);
      check_val("stall_mem", stall_mem, dm_req && !dm_ack);
   end

   task automatic exp_if(input logic [31:0] a);
      exp_grant.push_back('{is_dm: 1'b0, we: 1'b0, addr: a, wdata: 32'h0});
      exp_ack.push_back('{is_dm: 1'b0, data: rd_model(a)});
   endtask

   task automatic exp_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
      exp_grant.push_back('{is_dm: 1'b1, we: we, addr: a, wdata: d});
      exp_ack.push_back('{is_dm: 1'b1, data: rd_model(a)});
   endtask

   task automatic req_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
      dm_todo.push_back('{is_dm: 1'b1, we: we, addr: a, wdata: d});
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((if_todo.size() > 0 || dm_todo.size() > 0 || exp_ack.size() > 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_drain_pending"}, exp_ack.size(), 0);
   endtask

   // Both requesters held for 5 loads + 1 fetch: 4 DM grants, then IF, then the last DM
   task automatic starve_round(input logic [31:0] base);
      for (int i = 0; i < 4; i++) exp_dm(1'b0, base + 32'(i * 4), 32'h0);
      exp_if(base + 32'h800);
      exp_dm(1'b0, base + 32'h10, 32'h0);
      for (int i = 0; i < 5; i++) req_dm(1'b0, base + 32'(i * 4), 32'h0);
      if_todo.push_back(base + 32'h800);
      ack_cycs.delete();
      wait_drain("starve");
      check_val("starve_ack_count", ack_cycs.size(), 6);
      for (int i = 1; i < ack_cycs.size(); i++)
         check_val("b2b_spacing", ack_cycs[i] - ack_cycs[i-1], 3);
      check_val("wait_cnt_cleared", dut.wait_cnt, 0);
   endtask

   initial begin
      int t0;
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      // Reset values
      check_val("rst_mem_req", mem_req, 0);
      check_val("rst_mem_we", mem_we, 0);
      check_val("rst_mem_addr", mem_addr, 0);
      check_val("rst_mem_wdata", mem_wdata, 0);
      check_val("rst_if_ack", if_ack, 0);
      check_val("rst_dm_ack", dm_ack, 0);
      check_val("rst_if_rdata", if_rdata, 0);
      check_val("rst_dm_rdata", dm_rdata, 0);
      rst = 1'b0;

      // Idle: nothing moves for 10 cycles
      repeat (10) begin
         @(negedge clk);
         check_val("idle_mem_req", mem_req, 0);
         check_val("idle_acks", {if_ack, dm_ack}, 0);
         check_val("idle_stalls", {stall_if, stall_mem}, 0);
      end

      // Single fetch at minimum latency
      exp_if(32'h40);
      if_todo.push_back(32'h40);
      n = 0;
      do begin @(negedge clk); n++; end while (!if_req && n < 20);
      t0 = cyc;
      n = 0;
      while (!if_ack && n < 20) begin
         check_val("fetch_stall_if", stall_if, 1);
         @(negedge clk);
         n++;
      end
      check_val("fetch_ack_latency", cyc - t0, 2);
      check_val("fetch_if_rdata", if_rdata, 32'h2010000A);
      wait_drain("fetch");

      // Collision: store wins, fetch follows on the next IDLE
      exp_dm(1'b1, 32'h100, 32'hDEAD);
      exp_if(32'h200);
      req_dm(1'b1, 32'h100, 32'hDEAD);
      if_todo.push_back(32'h200);
      wait_drain("collide");

      // Starvation bound, twice to show the counter restarts from zero
      starve_round(32'h1000);
      starve_round(32'h2000);

      // Slow memory: 5 not-ready cycles, ack one cycle after ready
      mem_lat = 5;
      exp_if(32'h80);
      if_todo.push_back(32'h80);
      ack_cycs.delete();
      wait_drain("slow");
      check_val("slow_wait_cycles", ready_cyc - grant_cyc, 5);
      check_val("slow_ack_after_ready", ack_cycs.size() > 0 ? ack_cycs[$] - ready_cyc : -1, 1);
      mem_lat = 0;

      // Reset while the data access is stuck in DM_BUSY: abort with no ack
      mem_lat = 1000;
      exp_grant.push_back('{is_dm: 1'b1, we: 1'b1, addr: 32'h500, wdata: 32'hBEEF});
      req_dm(1'b1, 32'h500, 32'hBEEF);
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_req && n < 20);
      check_val("abort_mem_req_up", mem_req, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      dm_todo.delete();
      @(negedge clk);
      check_val("abort_mem_req", mem_req, 0);
      check_val("abort_mem_addr", mem_addr, 0);
      check_val("abort_state_idle", dut.state, 0);
      check_val("abort_dm_ack", dm_ack, 0);
      rst = 1'b0;
      mem_lat = 0;
      repeat (10) @(negedge clk);

      // Recovery after abort
      exp_dm(1'b0, 32'h504, 32'h0);
      req_dm(1'b0, 32'h504, 32'h0);
      wait_drain("recover");

      check_val("grants_left", exp_grant.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
